vga_timing_gen: RTL and testbench

// Generates the 640x480@60 Hz VGA raster timing from clock_50. Outputs:
//   - a 25 MHz pixel tick and pixel clock
//   - the current pixel coordinates x/y, for the upstream pixel painter
//   - hsync/vsync/n_blank, delayed by PIPE_DLY pixel ticks so they line up

---
 rtl/vga_pkg.sv | 40 ++++
 rtl/vga_delay_line.sv | 37 +++
 rtl/vga_timing_gen.sv | 101 ++++++++++
 tb/tb_vga_timing_gen.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA raster constants, the sync/blank bundle type and its decoder.
package vga_pkg;

  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;
  localparam int PIPE_DLY_DEF = 2;

  typedef struct packed {
    logic hs;
    logic vs;
    logic nb;
  } vga_sync_t;

  localparam vga_sync_t SYNC_IDLE = '{hs: 1'b1, vs: 1'b1, nb: 1'b0};

  // Sync pulses are active-low; nb is high only inside the visible window.
  function automatic vga_sync_t sync_decode(
    input logic [9:0] x,
    input logic [9:0] y,
    input int         h_act,
    input int         h_fp,
    input int         h_sync,
    input int         v_act,
    input int         v_fp,
    input int         v_sync
  );
    vga_sync_t s;
    s.hs = !((x >= 10'(h_act + h_fp)) && (x < 10'(h_act + h_fp + h_sync)));
    s.vs = !((y >= 10'(v_act + v_fp)) && (y < 10'(v_act + v_fp + v_sync)));
    s.nb = (x < 10'(h_act)) && (y < 10'(v_act));
    return s;
  endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Enabled shift register of DEPTH stages of an arbitrary type, with a
// synchronous reset that loads every stage with RST_VAL. DEPTH=0 is a wire.
module vga_delay_line #(
  parameter int  DEPTH   = 2,
  parameter type T       = logic,
  parameter T    RST_VAL = T'(0)
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  T     din,
  output T     dout
);

  generate
    if (DEPTH == 0) begin : g_bypass
      logic unused_ctrl;
      assign unused_ctrl = ^{clk, reset, en};
      assign dout = din;
    end else begin : g_shift
      T stage [DEPTH];

      // Shift one stage per enable; reset fills the whole line with RST_VAL.
      always_ff @(posedge clk) begin
        if (reset) begin
          for (int i = 0; i < DEPTH; i++) stage[i] <= RST_VAL;
        end else if (en) begin
          stage[0] <= din;
          for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
      end

      assign dout = stage[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// 640x480@60 raster timing from a 50 MHz clock: pixel strobe, coordinates,
// and sync/blank delayed by PIPE_DLY ticks to match the painter's latency.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF,
  parameter int PIPE_DLY = PIPE_DLY_DEF
) (
  input  logic       clock_50,
  input  logic       reset,
  output logic       pix_en,
  output logic       vgaclock,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       active,
  output logic       line_start,
  output logic       frame_start,
  output logic       hsync,
  output logic       vsync,
  output logic       n_blank
);

  localparam int         H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int         V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic [9:0] H_MAX   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_MAX   = 10'(V_TOTAL - 1);

  logic [9:0] x_next;
  logic [9:0] y_next;
  vga_sync_t  raw_next;
  vga_sync_t  raw_q;
  vga_sync_t  sync_out;

  // Next raster position: x wraps at line end, y advances only on that wrap.
  always_comb begin
    x_next = x;
    y_next = y;
    if (x == H_MAX) begin
      x_next = 10'd0;
      if (y == V_MAX) begin
        y_next = 10'd0;
      end else begin
        y_next = y + 10'd1;
      end
    end else begin
      x_next = x + 10'd1;
    end
  end

  // Decoding the upcoming position keeps raw_q aligned with x/y.
  always_comb begin
    raw_next = sync_decode(x_next, y_next, H_ACTIVE, H_FP, H_SYNC,
                           V_ACTIVE, V_FP, V_SYNC);
  end

  // Pixel strobe, pixel clock, counters and registered raw sync/blank.
  always_ff @(posedge clock_50) begin
    if (reset) begin
      pix_en   <= 1'b0;
      vgaclock <= 1'b0;
      x        <= 10'd0;
      y        <= 10'd0;
      raw_q    <= SYNC_IDLE;
    end else begin
      pix_en   <= ~pix_en;
      vgaclock <= pix_en;
      if (pix_en) begin
        x     <= x_next;
        y     <= y_next;
        raw_q <= raw_next;
      end
    end
  end

  vga_delay_line #(
    .DEPTH   (PIPE_DLY),
    .T       (vga_sync_t),
    .RST_VAL (SYNC_IDLE)
  ) u_sync_dly (
    .clk   (clock_50),
    .reset (reset),
    .en    (pix_en),
    .din   (raw_q),
    .dout  (sync_out)
  );

  assign hsync       = sync_out.hs;
  assign vsync       = sync_out.vs;
  assign n_blank     = sync_out.nb;
  assign active      = (x < 10'(H_ACTIVE)) && (y < 10'(V_ACTIVE));
  assign line_start  = pix_en && (x == 10'd0);
  assign frame_start = pix_en && (x == 10'd0) && (y == 10'd0);

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: full-size raster (PIPE_DLY 2 and 0) for line timing, and a
// short-frame raster (full lines, 8 lines/frame) for frame, wrap and mid-frame reset.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;

  always #10 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  logic       d2_pix_en, d2_vgaclock, d2_active, d2_line_start, d2_frame_start;
  logic       d2_hsync, d2_vsync, d2_n_blank;
  logic [9:0] d2_x, d2_y;
  logic       d0_pix_en, d0_vgaclock, d0_active, d0_line_start, d0_frame_start;
  logic       d0_hsync, d0_vsync, d0_n_blank;
  logic [9:0] d0_x, d0_y;
  logic       s_pix_en, s_vgaclock, s_active, s_line_start, s_frame_start;
  logic       s_hsync, s_vsync, s_n_blank;
  logic [9:0] s_x, s_y;

  vga_timing_gen #(.PIPE_DLY(2)) u_dut (
    .clock_50(clk), .reset(reset), .pix_en(d2_pix_en), .vgaclock(d2_vgaclock),
    .x(d2_x), .y(d2_y), .active(d2_active), .line_start(d2_line_start),
    .frame_start(d2_frame_start), .hsync(d2_hsync), .vsync(d2_vsync), .n_blank(d2_n_blank)
  );

  vga_timing_gen #(.PIPE_DLY(0)) u_dut_d0 (
    .clock_50(clk), .reset(reset), .pix_en(d0_pix_en), .vgaclock(d0_vgaclock),
    .x(d0_x), .y(d0_y), .active(d0_active), .line_start(d0_line_start),
    .frame_start(d0_frame_start), .hsync(d0_hsync), .vsync(d0_vsync), .n_blank(d0_n_blank)
  );

  // Lines 5..6 carry vsync; frame = 8 lines = 6400 ticks = 12800 clocks.
  vga_timing_gen #(.V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .PIPE_DLY(2)) u_dut_short (
    .clock_50(clk), .reset(reset), .pix_en(s_pix_en), .vgaclock(s_vgaclock),
    .x(s_x), .y(s_y), .active(s_active), .line_start(s_line_start),
    .frame_start(s_frame_start), .hsync(s_hsync), .vsync(s_vsync), .n_blank(s_n_blank)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  int  hs2_first = -1, hs2_last = -1, hs2_cnt = 0;
  int  nb2_first = -1, nb2_last = -1, nb2_cnt = 0;
  int  hs0_err = 0, nb0_err = 0, hs0_cnt = 0;
  int  epoch = 0, fs_n = 0, fs_start = 0;
  int  vs_cnt = 0, vs_fx = -1, vs_fy = -1, vs_lx = -1, vs_ly = -1;
  bit  wrap_pend = 1'b0, wrap_done = 1'b0, done = 1'b0;
  int  budget = 45000;

  initial begin
    reset = 1'b1;
    repeat (5) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_x", d2_x, 0);
    check("rst_y", d2_y, 0);
    check("rst_hsync", d2_hsync, 1);
    check("rst_vsync", d2_vsync, 1);
    check("rst_n_blank", d2_n_blank, 0);
    check("rst_pix_en", d2_pix_en, 0);
    check("rst_vgaclock", d2_vgaclock, 0);
    check("rst_frame_start", d2_frame_start, 0);
    @(negedge clk);
    check("first_pix_en", d2_pix_en, 1);
    check("first_frame_start", d2_frame_start, 1);
    check("first_line_start", d2_line_start, 1);
    check("first_vgaclock", d2_vgaclock, 0);

    while (!done && budget > 0) begin
      // Line timing on both full-size instances, second line only.
      if (epoch == 0 && d2_pix_en && d2_y == 10'd1) begin
        if (!d2_hsync) begin
          if (hs2_first < 0) hs2_first = int'(d2_x);
          hs2_last = int'(d2_x);
          hs2_cnt++;
        end
        if (d2_n_blank) begin
          if (nb2_first < 0) nb2_first = int'(d2_x);
          nb2_last = int'(d2_x);
          nb2_cnt++;
        end
      end
      if (epoch == 0 && d0_y == 10'd1) begin
        if (d0_hsync !== !(int'(d0_x) >= 656 && int'(d0_x) < 752)) hs0_err++;
        if (d0_n_blank !== d0_active) nb0_err++;
        if (d0_pix_en && !d0_hsync) hs0_cnt++;
      end

      // Short-frame instance: wrap, frame period and vsync window.
      if (wrap_pend && s_pix_en) begin
        check("wrap_x", s_x, 0);
        check("wrap_y", s_y, 0);
        check("wrap_frame_start", s_frame_start, 1);
        check("wrap_line_start", s_line_start, 1);
        wrap_pend = 1'b0;
        wrap_done = 1'b1;
      end
      if (!wrap_done && s_pix_en && s_x == 10'd799 && s_y == 10'd7) wrap_pend = 1'b1;

      if (s_frame_start) begin
        if (fs_n == 0) begin
          fs_start = cyc;
        end else if (fs_n == 1) begin
          check(epoch == 0 ? "frame_period" : "frame_period_after_rst", cyc - fs_start, 12800);
          check(epoch == 0 ? "vsync_ticks" : "vsync_ticks_after_rst", vs_cnt, 1600);
          if (epoch == 0) begin
            check("vsync_first_x", vs_fx, 2);
            check("vsync_first_y", vs_fy, 5);
            check("vsync_last_x", vs_lx, 1);
            check("vsync_last_y", vs_ly, 7);
          end else begin
            done = 1'b1;
          end
        end
        fs_n++;
      end
      if (s_pix_en && !s_vsync && fs_n == 1) begin
        vs_cnt++;
        if (vs_cnt == 1) begin
          vs_fx = int'(s_x);
          vs_fy = int'(s_y);
        end
        vs_lx = int'(s_x);
        vs_ly = int'(s_y);
      end

      // One-cycle reset in the middle of the second frame, inside vsync.
      if (epoch == 0 && fs_n >= 2 && s_pix_en && s_x == 10'd700 && s_y == 10'd5) begin
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("midrst_x", s_x, 0);
        check("midrst_y", s_y, 0);
        check("midrst_hsync", s_hsync, 1);
        check("midrst_vsync", s_vsync, 1);
        check("midrst_n_blank", s_n_blank, 0);
        check("midrst_pix_en", s_pix_en, 0);
        epoch  = 1;
        fs_n   = 0;
        vs_cnt = 0;
      end

      @(negedge clk);
      budget--;
    end

    if (!done) check("timeout", 0, 1);

    check("hs_fall_x", hs2_first, 658);
    check("hs_last_x", hs2_last, 753);
    check("hs_low_ticks", hs2_cnt, 96);
    check("nb_first_x", nb2_first, 2);
    check("nb_last_x", nb2_last, 641);
    check("nb_ticks", nb2_cnt, 640);
    check("d0_hsync_vs_x", hs0_err, 0);
    check("d0_nblank_vs_active", nb0_err, 0);
    check("d0_hs_low_ticks", hs0_cnt, 96);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
